// File: rtl/sound_ram_arb_if.sv
// Handshake bundle between the DOC fetch path, the GLU host path
// and the shared sound RAM.
interface sound_ram_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              doc_req;
  logic [ADDR_W-1:0] doc_addr;
  logic              doc_valid;
  logic [DATA_W-1:0] doc_data;
  logic              doc_overrun;
  logic              host_req;
  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  doc_req, doc_addr,
    input  host_req, host_wr,
    input  host_addr, host_wdata,
    input  ram_rdata,
    output doc_valid, doc_data,
    output doc_overrun,
    output host_ack, host_rdata,
    output ram_addr, ram_we,
    output ram_wdata
  );

  modport master (
    output doc_req, doc_addr,
    output host_req, host_wr,
    output host_addr, host_wdata,
    output ram_rdata,
    input  doc_valid, doc_data,
    input  doc_overrun,
    input  host_ack, host_rdata,
    input  ram_addr, ram_we,
    input  ram_wdata
  );
endinterface

// File: rtl/sound_ram_arb.sv
// Sound RAM arbiter: DOC reads with strict priority over
// GLU host reads/writes, serialized onto one sync RAM.
module sound_ram_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input logic           CLK_14M,
  input logic           reset,
  sound_ram_arb_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DOC_A = 3'd1;
  localparam logic [2:0] DOC_D = 3'd2;
  localparam logic [2:0] HST_A = 3'd3;
  localparam logic [2:0] HST_D = 3'd4;
  localparam logic [2:0] HST_W = 3'd5;

  logic [2:0]        state;
  logic              doc_pend;
  logic [ADDR_W-1:0] doc_pend_addr;
  logic              doc_valid;
  logic [DATA_W-1:0] doc_data;
  logic              doc_overrun;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;

  logic doc_take;
  logic doc_consume;
  logic doc_direct;
  logic host_go;

  assign doc_take    = (state == IDLE)
                     && (doc_pend || bus.doc_req);
  assign doc_consume = doc_take && doc_pend;
  assign doc_direct  = doc_take && !doc_pend;
  assign host_go     = bus.host_req && !host_ack;

  assign bus.doc_valid   = doc_valid;
  assign bus.doc_data    = doc_data;
  assign bus.doc_overrun = doc_overrun;
  assign bus.host_ack    = host_ack;
  assign bus.host_rdata  = host_rdata;
  assign bus.ram_addr    = ram_addr;
  assign bus.ram_we      = ram_we;
  assign bus.ram_wdata   = ram_wdata;

  // One-entry DOC queue; a request that arrives while the
  // slot is freed this edge takes the slot instead of dropping.
  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      doc_pend      <= 1'b0;
      doc_pend_addr <= '0;
      doc_overrun   <= 1'b0;
    end else begin
      if (bus.doc_req && !doc_direct) begin
        if (doc_pend && !doc_consume) begin
          doc_overrun <= 1'b1;
        end else begin
          doc_pend      <= 1'b1;
          doc_pend_addr <= bus.doc_addr;
        end
      end else if (doc_consume) begin
        doc_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      doc_valid  <= 1'b0;
      doc_data   <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
    end else begin
      doc_valid <= 1'b0;
      host_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (doc_take) begin
            ram_addr <= doc_pend ? doc_pend_addr
                                 : bus.doc_addr;
            ram_we   <= 1'b0;
            state    <= DOC_A;
          end else if (host_go) begin
            ram_addr <= bus.host_addr;
            if (bus.host_wr) begin
              ram_wdata <= bus.host_wdata;
              ram_we    <= 1'b1;
              state     <= HST_W;
            end else begin
              state <= HST_A;
            end
          end
        end
        DOC_A: state <= DOC_D;
        DOC_D: begin
          doc_data  <= bus.ram_rdata;
          doc_valid <= 1'b1;
          state     <= IDLE;
        end
        HST_A: state <= HST_D;
        HST_D: begin
          host_rdata <= bus.ram_rdata;
          host_ack   <= 1'b1;
          state      <= IDLE;
        end
        HST_W: begin
          ram_we   <= 1'b0;
          host_ack <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sound_ram_arb.sv
// Directed bench for sound_ram_arb: vector table plus
// hand sequences for queueing, overrun and reset abort.
module tb_sound_ram_arb;
  logic CLK_14M = 1'b0;
  logic reset   = 1'b1;
  always #5 CLK_14M = ~CLK_14M;

  sound_ram_arb_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  sound_ram_arb #(.ADDR_W(16), .DATA_W(8)) dut (
    .CLK_14M (CLK_14M),
    .reset   (reset),
    .bus     (bus.slave)
  );

  logic [7:0] mem [0:65535];
  always @(posedge CLK_14M) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        dreq;
    logic [15:0] daddr;
    logic        hreq;
    logic        hwr;
    logic [15:0] haddr;
    logic [7:0]  hwd;
    logic        dv;
    logic [7:0]  dd;
    logic        ha;
    logic [7:0]  hr;
    logic        we;
    logic [15:0] ra;
  } vec_t;

  vec_t tv [20];

  function automatic vec_t mk(
    input logic dreq, input logic [15:0] daddr,
    input logic hreq, input logic hwr,
    input logic [15:0] haddr, input logic [7:0] hwd,
    input logic dv, input logic [7:0] dd,
    input logic ha, input logic [7:0] hr,
    input logic we, input logic [15:0] ra);
    vec_t v;
    v.dreq = dreq; v.daddr = daddr;
    v.hreq = hreq; v.hwr = hwr;
    v.haddr = haddr; v.hwd = hwd;
    v.dv = dv; v.dd = dd; v.ha = ha;
    v.hr = hr; v.we = we; v.ra = ra;
    return v;
  endfunction

  task automatic drive_idle();
    bus.doc_req    = 1'b0;
    bus.doc_addr   = 16'h0;
    bus.host_req   = 1'b0;
    bus.host_wr    = 1'b0;
    bus.host_addr  = 16'h0;
    bus.host_wdata = 8'h0;
  endtask

  task automatic step();
    @(posedge CLK_14M);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {29'd0, bus.doc_valid, bus.doc_data,
            bus.host_ack, bus.host_rdata,
            bus.ram_we, bus.ram_addr};
  endfunction

  function automatic logic [63:0] all_outs();
    return {19'd0, bus.doc_valid, bus.doc_data,
            bus.doc_overrun, bus.host_ack,
            bus.host_rdata, bus.ram_addr,
            bus.ram_we, bus.ram_wdata};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    bit got;
    logic [7:0] dq [$];

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    mem[16'h0010] = 8'h11;
    mem[16'h0020] = 8'h22;
    drive_idle();

    tv[0]  = mk(1,16'h1234,0,0,16'h0,8'h0,
                0,8'h00,0,8'h00,0,16'h1234);
    tv[1]  = mk(0,16'h0,0,0,16'h0,8'h0,
                0,8'h00,0,8'h00,0,16'h1234);
    tv[2]  = mk(0,16'h0,0,0,16'h0,8'h0,
                1,8'hA5,0,8'h00,0,16'h1234);
    tv[3]  = mk(0,16'h0,0,0,16'h0,8'h0,
                0,8'hA5,0,8'h00,0,16'h1234);
    tv[4]  = mk(0,16'h0,1,1,16'hFFFF,8'h5A,
                0,8'hA5,0,8'h00,1,16'hFFFF);
    tv[5]  = mk(0,16'h0,1,1,16'hFFFF,8'h5A,
                0,8'hA5,1,8'h00,0,16'hFFFF);
    tv[6]  = mk(0,16'h0,1,1,16'hFFFF,8'h5A,
                0,8'hA5,0,8'h00,0,16'hFFFF);
    tv[7]  = mk(0,16'h0,0,0,16'h0,8'h0,
                0,8'hA5,0,8'h00,0,16'hFFFF);
    tv[8]  = mk(0,16'h0,1,0,16'hFFFF,8'h0,
                0,8'hA5,0,8'h00,0,16'hFFFF);
    tv[9]  = mk(0,16'h0,1,0,16'hFFFF,8'h0,
                0,8'hA5,0,8'h00,0,16'hFFFF);
    tv[10] = mk(0,16'h0,1,0,16'hFFFF,8'h0,
                0,8'hA5,1,8'h5A,0,16'hFFFF);
    tv[11] = mk(0,16'h0,1,0,16'hFFFF,8'h0,
                0,8'hA5,0,8'h5A,0,16'hFFFF);
    tv[12] = mk(0,16'h0,0,0,16'h0,8'h0,
                0,8'hA5,0,8'h5A,0,16'hFFFF);
    tv[13] = mk(1,16'h0010,1,0,16'h0020,8'h0,
                0,8'hA5,0,8'h5A,0,16'h0010);
    tv[14] = mk(0,16'h0,1,0,16'h0020,8'h0,
                0,8'hA5,0,8'h5A,0,16'h0010);
    tv[15] = mk(0,16'h0,1,0,16'h0020,8'h0,
                1,8'h11,0,8'h5A,0,16'h0010);
    tv[16] = mk(0,16'h0,1,0,16'h0020,8'h0,
                0,8'h11,0,8'h5A,0,16'h0020);
    tv[17] = mk(0,16'h0,1,0,16'h0020,8'h0,
                0,8'h11,0,8'h5A,0,16'h0020);
    tv[18] = mk(0,16'h0,1,0,16'h0020,8'h0,
                0,8'h11,1,8'h22,0,16'h0020);
    tv[19] = mk(0,16'h0,0,0,16'h0,8'h0,
                0,8'h11,0,8'h22,0,16'h0020);

    #12;
    chk("reset_outputs", all_outs(), 64'd0);
    @(negedge CLK_14M);
    reset = 1'b0;
    step();

    foreach (tv[i]) begin
      bus.doc_req    = tv[i].dreq;
      bus.doc_addr   = tv[i].daddr;
      bus.host_req   = tv[i].hreq;
      bus.host_wr    = tv[i].hwr;
      bus.host_addr  = tv[i].haddr;
      bus.host_wdata = tv[i].hwd;
      step();
      chk($sformatf("vec%0d", i), outs(),
          {29'd0, tv[i].dv, tv[i].dd, tv[i].ha,
           tv[i].hr, tv[i].we, tv[i].ra});
    end
    drive_idle();
    step();

    // DOC request arriving one cycle into a host write
    bus.host_req   = 1'b1;
    bus.host_wr    = 1'b1;
    bus.host_addr  = 16'h0100;
    bus.host_wdata = 8'h77;
    step();
    chk("dwr_we", {63'd0, bus.ram_we}, 64'd1);
    bus.doc_req  = 1'b1;
    bus.doc_addr = 16'h1234;
    step();
    n = 1;
    acks = int'(bus.host_ack);
    drive_idle();
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      n++;
      acks += int'(bus.host_ack);
      if (bus.doc_valid) got = 1'b1;
    end
    chk("dwr_valid_seen", {63'd0, got}, 64'd1);
    chk("dwr_latency_le5", {63'd0, n <= 5}, 64'd1);
    chk("dwr_data", {56'd0, bus.doc_data}, 64'hA5);
    chk("dwr_overrun", {63'd0, bus.doc_overrun}, 64'd0);
    chk("dwr_acks", 64'(acks), 64'd1);
    chk("dwr_mem", {56'd0, mem[16'h0100]}, 64'h77);
    step();
    step();

    // Three back-to-back DOC requests: third is dropped
    for (int i = 0; i < 10; i++) begin
      bus.doc_req  = (i < 3);
      bus.doc_addr = (i == 0) ? 16'h0010 :
                     (i == 1) ? 16'h0020 : 16'h1234;
      step();
      if (bus.doc_valid) dq.push_back(bus.doc_data);
    end
    drive_idle();
    chk("ovr_count", 64'(dq.size()), 64'd2);
    if (dq.size() == 2) begin
      chk("ovr_first", {56'd0, dq[0]}, 64'h11);
      chk("ovr_second", {56'd0, dq[1]}, 64'h22);
    end
    chk("ovr_flag", {63'd0, bus.doc_overrun}, 64'd1);
    for (int i = 0; i < 6; i++) step();
    chk("ovr_sticky", {63'd0, bus.doc_overrun}, 64'd1);

    // Reset in the middle of a host write
    bus.host_req   = 1'b1;
    bus.host_wr    = 1'b1;
    bus.host_addr  = 16'h0200;
    bus.host_wdata = 8'h99;
    step();
    chk("rst_we_before", {63'd0, bus.ram_we}, 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_we_async", {63'd0, bus.ram_we}, 64'd0);
    chk("rst_no_ack", {63'd0, bus.host_ack}, 64'd0);
    drive_idle();
    step();
    @(negedge CLK_14M);
    reset = 1'b0;
    #1;
    chk("rst_all_zero", all_outs(), 64'd0);
    chk("rst_no_write", {56'd0, mem[16'h0200]}, 64'h00);
    step();

    bus.host_req  = 1'b1;
    bus.host_wr   = 1'b0;
    bus.host_addr = 16'hFFFF;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      n++;
      if (bus.host_ack) got = 1'b1;
    end
    chk("post_rst_ack", {63'd0, got}, 64'd1);
    chk("post_rst_latency", 64'(n), 64'd3);
    chk("post_rst_rdata", {56'd0, bus.host_rdata}, 64'h5A);
    drive_idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sound_ram_arb.md
# sound_ram_arb

Arbiter and sequencer for the 64 KB sound RAM shared by the ES5503 DOC sample fetch path and the Sound GLU host path. It accepts single-byte DOC read requests and GLU read/write requests, and serializes them onto one synchronous single-port RAM. DOC requests have strict priority. It sits between `soundglu`/`es5503` and `syncram`, replacing ad-hoc address muxing with an explicit handshake.

## Interface
- `ADDR_W`, default 16: RAM address width.
- `DATA_W`, default 8: RAM data width.

- `CLK_14M` in 1: sole clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `doc_req` in 1: one-cycle pulse; DOC requests a read of `doc_addr`.
- `doc_addr` in ADDR_W: DOC read address, sampled in the cycle `doc_req` is high.
- `doc_valid` out 1: one-cycle pulse; `doc_data` is valid.
- `doc_data` out DATA_W: DOC read data, held until the next DOC read completes.
- `doc_overrun` out 1: sticky flag; a DOC request was dropped.
- `host_req` in 1: level request, held until `host_ack`.
- `host_wr` in 1: 1 = write, 0 = read; held stable with `host_req`.
- `host_addr` in ADDR_W: host address, held stable with `host_req`.
- `host_wdata` in DATA_W: host write data, held stable with `host_req`.
- `host_ack` out 1: one-cycle pulse; access done (`host_rdata` valid for reads).
- `host_rdata` out DATA_W: host read data, held until the next host read completes.
- `ram_addr` out ADDR_W: RAM address, registered.
- `ram_we` out 1: RAM write enable, registered.
- `ram_wdata` out DATA_W: RAM write data, registered.
- `ram_rdata` in DATA_W: RAM read data; valid one edge after `ram_addr` is sampled.

## Operation
- DOC request capture:
  - `doc_req` high captures `doc_addr` into `doc_pend`/`doc_pend_addr` (one-entry queue).
  - If `doc_pend` is already set, the new request is dropped and `doc_overrun` is set.
  - `doc_overrun` is cleared only by reset.
  - A `doc_req` in the same cycle that `doc_pend` is consumed is captured, not dropped.
- FSM states: IDLE, DOC_A, DOC_D, HST_A, HST_D, HST_W.
- In IDLE, evaluated on each edge:
  - If `doc_pend` (or `doc_req` this cycle): `ram_addr`←DOC address, `ram_we`←0, clear pend, go to DOC_A.
  - Else if `host_req` and not `host_ack`, for a read: `ram_addr`←`host_addr`, go to HST_A.
  - Else if `host_req` and not `host_ack`, for a write: `ram_addr`/`ram_wdata`←host values, `ram_we`←1, go to HST_W.
  - Otherwise stay in IDLE.
- DOC_A → DOC_D, unconditionally; the RAM samples the address on this edge.
- DOC_D → IDLE: `doc_data`←`ram_rdata`, `doc_valid`←1.
- HST_A → HST_D, unconditionally.
- HST_D → IDLE: `host_rdata`←`ram_rdata`, `host_ack`←1.
- HST_W → IDLE: `ram_we`←0, `host_ack`←1.
- Host request suppression: `host_req` is ignored while `host_ack` is high, so a requester that deasserts on the edge after the ack is not serviced twice.
- Strict priority: a pending DOC request always wins in IDLE. Host starvation is bounded only by the DOC request rate.
- An access in progress is never preempted.
- `ram_addr` and `ram_wdata` hold their last value in IDLE; `ram_we` is 0 except in HST_W.

## Timing
- Reset values:
  - State IDLE; `doc_pend` 0.
  - `doc_valid`, `doc_overrun`, `host_ack`, and `ram_we` all 0.
  - `doc_data`, `host_rdata`, `ram_addr`, and `ram_wdata` all 0.
- Reset mid-access aborts the access with no ack or valid pulse. `ram_we` drops immediately (asynchronous). The host must reissue.
- DOC latency, arbiter idle: `doc_req` sampled at edge k → `doc_valid` high for the cycle after edge k+2.
- Worst-case DOC latency: +2 edges, when it lands just after a host access starts. `doc_req` spacing ≥ 6 cycles guarantees no overrun.
- Host read: `host_req` sampled at edge k, no DOC pending → `host_ack` after edge k+2.
- Host write: `ram_we` high during the cycle after edge k → `host_ack` after edge k+1.
- Simultaneous `doc_req` and `host_req` in IDLE: DOC is granted first. The host is granted on the first IDLE edge with no DOC pending.
- Address wrap is not applicable; addresses pass through unmodified.

## Test plan
- DOC read, idle arbiter: preload RAM[0x1234]=0xA5; pulse `doc_req` with `doc_addr`=0x1234 → `doc_valid`=1 exactly 3 edges later, `doc_data`=0xA5, `host_ack` stays 0.
- Host write then read: write 0x5A to 0xFFFF → `ram_we` pulse of 1 cycle, ack 2 edges after request. Reading 0xFFFF back → `host_rdata`=0x5A with ack 3 edges after request. Exactly one ack per request while `host_req` is held through the ack.
- Contention: `doc_req` (0x0010, RAM=0x11) and a `host_req` read (0x0020, RAM=0x22) in the same cycle → `doc_valid` with 0x11 first. `host_ack` with 0x22 three edges later.
- DOC during host access: start host write, pulse `doc_req` one cycle later → write completes, then DOC served. `doc_valid` ≤5 edges after `doc_req`, `doc_overrun`=0.
- Overrun: three `doc_req` pulses on consecutive cycles → first two served in order, third dropped, `doc_overrun`=1 and sticky until reset.
- Reset mid-operation: assert `reset` during HST_W → `ram_we`=0 immediately, no `host_ack`. After release all outputs are 0 and a new host read completes normally.
